weight_stream_reader: RTL and testbench

// - Read-side sequencer for one 16-bit weight BRAM (EN/WE/ADDR/DI/DO, negedge-clocked, 1-cycle read).
// - On START, fetches addresses 0..DEPTH-1 in order and streams the weights to the neuron MAC over valid/ready.
// - Sits between a weight BRAM and its neuron datapath; one instance per BRAM; never writes the BRAM.

---
 rtl/weight_stream_reader.sv | 230 +++++++++++++++++++++++
 tb/tb_weight_stream_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_reader.sv
// weight_stream_reader
// Read-side sequencer for a single 16-bit weight BRAM.
// - The BRAM is negedge-clocked with a 1-cycle read.
// - On START the block reads words 0..DEPTH-1 in order.
// - The weights go to the neuron MAC over a valid/ready stream.
// Optional feature: define WSR_CHECKSUM_EN to add a CHECKSUM output.
//   CHECKSUM is the running modulo-2**DW sum of all transferred weights.
//
// Handshake: a weight moves when W_VALID and W_READY are both high at a
// posedge of CLK. W_VALID never depends on W_READY. While W_VALID is high
// and W_READY is low, W_DATA/W_INDEX/W_LAST hold their values.
//
// Read pipeline: BRAM_EN/BRAM_ADDR are registered. A read is issued in the
// cycle where BRAM_EN is high. The BRAM latches the address at the
// negedge, and the data is pushed into a 2-entry FIFO at the following
// posedge. A new read is launched only if the FIFO occupancy after the
// current edge (count + in-flight read - pop) is below 2, so the FIFO can
// never overflow.
module weight_stream_reader #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] BRAM_ADDR,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    output logic [DW-1:0] BRAM_DI,
    input  logic [DW-1:0] BRAM_DO,
    output logic [DW-1:0] W_DATA,
    output logic [AW-1:0] W_INDEX,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic          W_LAST
`ifdef WSR_CHECKSUM_EN
    ,
    output logic [DW-1:0] CHECKSUM
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    // Read issue registers; r_bram_en doubles as the in-flight flag.
    logic          r_bram_en;
    logic [AW-1:0] r_bram_addr;
    logic [AW-1:0] r_rd_ptr;

    // Two-entry output FIFO; entry 0 is the head.
    logic [1:0]    r_count;
    logic [DW-1:0] r_data0;
    logic [DW-1:0] r_data1;
    logic [AW-1:0] r_idx0;
    logic [AW-1:0] r_idx1;

    logic          w_issue;
    logic [AW-1:0] w_issue_addr;
    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_occ;
    logic          w_start_acc;

    // Handshake and occupancy bookkeeping.
    always_comb begin
        w_pop        = (r_count != 2'd0) && W_READY;
        w_push       = r_bram_en;
        w_occ        = {1'b0, r_count} + {2'b00, r_bram_en} - {2'b00, w_pop};
        w_issue_addr = (r_state == S_IDLE) ? '0 : r_rd_ptr;
        w_start_acc  = (r_state == S_IDLE) && START;
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and read-issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_issue     = 1'b1;
                    w_state_nxt = (w_issue_addr == LAST_ADDR) ? S_DRAIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_occ < 3'd2) begin
                    w_issue = 1'b1;
                    if (r_rd_ptr == LAST_ADDR) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && W_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        BUSY = (r_state == S_FETCH) || (r_state == S_DRAIN);
        DONE = (r_state == S_DONE);
    end

    // Read issue registers and address pointer; the pointer parks on the last address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_bram_en <= w_issue;
            if (w_issue) begin
                r_bram_addr <= w_issue_addr;
                r_rd_ptr    <= (w_issue_addr == LAST_ADDR) ? w_issue_addr
                                                           : w_issue_addr + AW'(1);
            end
        end
    end

    // The BRAM interface is read-only.
    always_comb begin
        BRAM_EN   = r_bram_en;
        BRAM_ADDR = r_bram_addr;
        BRAM_WE   = 1'b0;
        BRAM_DI   = '0;
    end

    // Output FIFO: capture the returning read data and pop on transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_idx0  <= '0;
            r_idx1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= BRAM_DO;
                        r_idx0  <= r_bram_addr;
                    end else begin
                        r_data1 <= BRAM_DO;
                        r_idx1  <= r_bram_addr;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_idx0  <= r_idx1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= BRAM_DO;
                        r_idx0  <= r_bram_addr;
                    end else begin
                        r_data0 <= r_data1;
                        r_idx0  <= r_idx1;
                        r_data1 <= BRAM_DO;
                        r_idx1  <= r_bram_addr;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // The stream outputs come from the FIFO head.
    always_comb begin
        W_VALID = (r_count != 2'd0);
        W_DATA  = r_data0;
        W_INDEX = r_idx0;
        W_LAST  = W_VALID && (r_idx0 == LAST_ADDR);
    end

`ifdef WSR_CHECKSUM_EN
    logic [DW-1:0] r_checksum;

    // Running sum of transferred weights; it restarts with each accepted START.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + r_data0;
        end
    end

    assign CHECKSUM = r_checksum;
`else
    logic w_unused;

    // The start-accept term is only consumed by the checksum.
    assign w_unused = w_start_acc;
`endif

endmodule

// File: tb/tb_weight_stream_reader.sv
// tb_weight_stream_reader
// Bench for weight_stream_reader.
// - A behavioural negedge BRAM model holds the weights.
// - The expected stream for a pass is the memory contents in address
//   order. The bench keeps it in a queue and pops it on each transfer.
// - A negedge monitor compares every transfer against that queue.
// - The monitor also checks stall stability, issue ordering, the
//   outstanding-read limit and DONE timing.
// Define WSR_CHECKSUM_EN to also check CHECKSUM.
module tb_weight_stream_reader;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int EW    = 1 + AW + DW;

    logic          CLK;
    logic          RST;
    logic          START;
    logic          BUSY;
    logic          DONE;
    logic [AW-1:0] BRAM_ADDR;
    logic          BRAM_EN;
    logic          BRAM_WE;
    logic [DW-1:0] BRAM_DI;
    logic [DW-1:0] BRAM_DO = '0;
    logic [DW-1:0] W_DATA;
    logic [AW-1:0] W_INDEX;
    logic          W_VALID;
    logic          W_READY;
    logic          W_LAST;
`ifdef WSR_CHECKSUM_EN
    logic [DW-1:0] CHECKSUM;
`endif

    weight_stream_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WE   (BRAM_WE),
        .BRAM_DI   (BRAM_DI),
        .BRAM_DO   (BRAM_DO),
        .W_DATA    (W_DATA),
        .W_INDEX   (W_INDEX),
        .W_VALID   (W_VALID),
        .W_READY   (W_READY),
        .W_LAST    (W_LAST)
`ifdef WSR_CHECKSUM_EN
        ,
        .CHECKSUM  (CHECKSUM)
`endif
    );

    // Clock and global watchdog.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural BRAM: it latches the address at negedge when enabled.
    logic [DW-1:0] mem [0:31];
    always @(negedge CLK) begin
        if (BRAM_EN && !BRAM_WE) BRAM_DO <= mem[BRAM_ADDR];
    end

    // Scoreboard state.
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] exp_sum;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor state.
    bit            mon_en = 1'b0;
    int            mon_cyc;
    int            mon_issued;
    int            mon_xfer;
    int            mon_done;
    int            mon_last_xfer_cyc;
    int            mon_first_valid;
    int            mon_first_busy;
    bit            prev_stall;
    logic [EW-1:0] prev_out;

    always @(negedge CLK) begin
        if (mon_en && !RST) begin
            if (BRAM_EN) begin
                check("issue_addr", 64'(BRAM_ADDR), 64'(mon_issued));
                check("outstanding_lt2", 64'((mon_issued - mon_xfer) <= 1), 64'd1);
                mon_issued++;
            end
            if (BRAM_WE || BRAM_DI != '0)
                check("bram_we_di_zero", {BRAM_WE, BRAM_DI}, 64'd0);
            if (prev_stall)
                check("stall_hold", {W_VALID, W_LAST, W_INDEX, W_DATA}, {1'b1, prev_out});
            if (W_VALID && mon_first_valid < 0) mon_first_valid = mon_cyc;
            if (BUSY && mon_first_busy < 0) mon_first_busy = mon_cyc;
            if (W_VALID && W_READY) begin
                if (exp_q.size() == 0) begin
                    check("extra_xfer", 64'(mon_xfer), 64'(DEPTH));
                end else begin
                    check("xfer", {W_LAST, W_INDEX, W_DATA}, exp_q.pop_front());
                end
                mon_xfer++;
                mon_last_xfer_cyc = mon_cyc;
            end
            if (DONE) begin
                mon_done++;
                check("done_after_last", 64'(mon_cyc - mon_last_xfer_cyc), 64'd1);
                check("done_busy_low", 64'(BUSY), 64'd0);
                check("done_all_xfers", 64'(mon_xfer), 64'(DEPTH));
`ifdef WSR_CHECKSUM_EN
                check("checksum", 64'(CHECKSUM), 64'(exp_sum));
`endif
            end
            prev_stall = W_VALID && !W_READY;
            prev_out   = {W_LAST, W_INDEX, W_DATA};
            mon_cyc++;
        end
    end

    // Model: load the memory and build the expected stream from it.
    task automatic load_mem(input bit randdata);
        exp_q.delete();
        exp_sum = '0;
        for (int i = 0; i < 32; i++) mem[i] = 16'hDEAD;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = randdata ? DW'($urandom_range(0, 65535)) : DW'(16'h0100 + i);
            exp_q.push_back({(i == DEPTH - 1), AW'(i), mem[i]});
            exp_sum = exp_sum + mem[i];
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0: return 1'b1;
            1: return (k % 2 == 0);
            2: return 1'($urandom_range(0, 1));
            3: return (k > 10);
            default: return 1'b1;
        endcase
    endfunction

    task automatic begin_pass(input int mode);
        @(posedge CLK); #1;
        mon_cyc = 0; mon_issued = 0; mon_xfer = 0; mon_done = 0;
        mon_last_xfer_cyc = -100; mon_first_valid = -1; mon_first_busy = -1;
        prev_stall = 1'b0;
        mon_en  = 1'b1;
        START   = 1'b1;
        W_READY = ready_for(mode, 0);
    endtask

    // Driver: one full pass. The cycle in which START is high is cycle 0.
    task automatic run_pass(input int mode, input bit repulse, input bit randdata);
        int k;
        int post;
        load_mem(randdata);
        begin_pass(mode);
        k = 1;
        post = 0;
        while (k < 600 && post < 5) begin
            @(posedge CLK); #1;
            START   = repulse && (k == 3 || k == 15);
            W_READY = ready_for(mode, k);
            if (mode == 3 && k == 11) check("stall_two_reads", 64'(mon_issued), 64'd2);
            if (mon_done > 0) post++;
            k++;
        end
        if (post < 5) check("pass_timeout", 64'(k), 64'd0);
        START = 1'b0;
    endtask

    typedef struct {
        int mode;
        bit repulse;
        bit randdata;
        int exp_xfers;
        int exp_dones;
        int exp_first_valid;
        int exp_first_busy;
    } vec_t;

    vec_t tbl[6];

    initial begin
        RST = 1'b1; START = 1'b0; W_READY = 1'b0;
        tbl[0] = '{0, 1'b0, 1'b0, DEPTH, 1, 2, 1};
        tbl[1] = '{1, 1'b0, 1'b0, DEPTH, 1, 2, 1};
        tbl[2] = '{2, 1'b0, 1'b1, DEPTH, 1, 2, 1};
        tbl[3] = '{3, 1'b0, 1'b1, DEPTH, 1, 2, 1};
        tbl[4] = '{4, 1'b1, 1'b0, DEPTH, 1, 2, 1};
        tbl[5] = '{2, 1'b1, 1'b1, DEPTH, 1, 2, 1};

        // Reset state.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs",
              {BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_LAST, BRAM_ADDR, W_INDEX, W_DATA, BRAM_DI},
              64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Table-driven passes.
        for (int t = 0; t < 6; t++) begin
            run_pass(tbl[t].mode, tbl[t].repulse, tbl[t].randdata);
            check("pass_xfers", 64'(mon_xfer), 64'(tbl[t].exp_xfers));
            check("pass_dones", 64'(mon_done), 64'(tbl[t].exp_dones));
            check("pass_reads", 64'(mon_issued), 64'(DEPTH));
            check("pass_q_empty", 64'(exp_q.size()), 64'd0);
            check("first_valid_cyc", 64'(mon_first_valid), 64'(tbl[t].exp_first_valid));
            check("first_busy_cyc", 64'(mon_first_busy), 64'(tbl[t].exp_first_busy));
            check("idle_after_pass", {BUSY, DONE, W_VALID, BRAM_EN}, 64'd0);
`ifdef WSR_CHECKSUM_EN
            if (!tbl[t].randdata) check("checksum_fixed", 64'(CHECKSUM), 64'h1D7A);
`endif
        end

        // Reset while transfer 12 is being offered.
        begin
            int guard;
            load_mem(1'b0);
            begin_pass(0);
            guard = 0;
            while (mon_xfer < 12 && guard < 100) begin
                @(posedge CLK); #1;
                START = 1'b0;
                guard++;
            end
            check("reached_xfer12", 64'(mon_xfer), 64'd12);
            RST = 1'b1;
            mon_en = 1'b0;
            @(posedge CLK); #1;
            RST = 1'b0;
            @(negedge CLK);
            check("rst_mid_outputs", {W_VALID, BUSY, DONE, BRAM_EN}, 64'd0);
            for (int i = 0; i < 6; i++) begin
                @(negedge CLK);
                check("rst_no_done", {DONE, BUSY}, 64'd0);
            end
        end

        // A fresh pass after the abort must restart at index 0.
        run_pass(0, 1'b0, 1'b0);
        check("restart_xfers", 64'(mon_xfer), 64'(DEPTH));
        check("restart_dones", 64'(mon_done), 64'd1);
        check("restart_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
